// File: rtl/openhw_ram1p_req_ctrl_if.sv
// Request/response handshake bundle between an initiator and the RAM request controller.
// Both streams use valid/ready: a beat transfers on a rising clk edge where valid & ready are both high.
interface openhw_ram1p_req_ctrl_if #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 44
);
  localparam int AW = $clog2(DEPTH);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/openhw_ram1p_req_ctrl.sv
// Initiator-side controller for a single-port read-first RAM: request stream in,
// read responses out through a 3-entry FIFO, plus a full-array clear sequencer.
module openhw_ram1p_req_ctrl #(
  parameter int               DEPTH         = 64,
  parameter int               WIDTH         = 44,
  parameter bit               INIT_ON_RESET = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init_start,
  output logic                       init_busy,
  openhw_ram1p_req_ctrl_if.slave     bus,
  output logic                       ram_ce,
  output logic                       ram_we,
  output logic [$clog2(DEPTH)-1:0]   ram_addr,
  output logic [WIDTH-1:0]           ram_din,
  input  logic [WIDTH-1:0]           ram_dout,
  output logic [1:0]                 dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_READY = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    clr_cnt;
  logic             rd_pend;
  logic [WIDTH-1:0] fifo_mem [3];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [1:0]       fifo_count;

  logic credit_ok;
  logic req_ready_int;
  logic fire;
  logic fire_rd;
  logic push;
  logic pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts both buffered entries and the read whose data lands next edge,
  // so a full FIFO is never pushed and there is no rsp_ready->req_ready path.
  assign credit_ok     = ({1'b0, fifo_count} + {2'b00, rd_pend}) < 3'd3;
  assign req_ready_int = !reset && (state == ST_READY) && credit_ok;
  assign fire          = bus.req_valid && req_ready_int;
  assign fire_rd       = fire && !bus.req_we;
  assign push          = rd_pend;
  assign pop           = (fifo_count != 2'd0) && bus.rsp_ready;

  assign bus.req_ready = req_ready_int;
  assign bus.rsp_valid = (fifo_count != 2'd0);
  assign bus.rsp_rdata = fifo_mem[rd_ptr];
  assign init_busy     = (state != ST_READY);
  assign dbg_state     = state;

  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!reset) begin
      case (state)
        ST_INIT: begin
          ram_ce   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = clr_cnt;
          ram_din  = INIT_VALUE;
        end
        ST_READY: begin
          ram_ce   = fire;
          ram_we   = fire && bus.req_we;
          ram_addr = bus.req_addr;
          ram_din  = bus.req_wdata;
        end
        default: begin
          ram_ce = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT_ON_RESET ? ST_INIT : ST_READY;
      clr_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (clr_cnt == LAST_ADDR) begin
            clr_cnt <= '0;
            state   <= ST_READY;
          end else begin
            clr_cnt <= clr_cnt + AW'(1);
          end
        end
        ST_READY: begin
          if (init_start) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!rd_pend && fifo_count == 2'd0) state <= ST_INIT;
        end
        default: state <= ST_READY;
      endcase
    end
  end

  // Read pipeline and response FIFO; reset drops any in-flight or buffered data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend    <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 2'd0;
    end else begin
      rd_pend <= fire_rd;
      if (push) begin
        fifo_mem[wr_ptr] <= ram_dout;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && fifo_count == 2'd3));
    end
  end
endmodule

// File: tb/tb_openhw_ram1p_req_ctrl.sv
// Directed bench for openhw_ram1p_req_ctrl with a behavioural read-first RAM model.
module tb_openhw_ram1p_req_ctrl;
  localparam int DEPTH = 64;
  localparam int W     = 44;
  localparam int AW    = 6;

  localparam logic [W-1:0] D1   = 44'h111_0000_0001;
  localparam logic [W-1:0] D2   = 44'h222_0000_0002;
  localparam logic [W-1:0] D3   = 44'h333_0000_0003;
  localparam logic [W-1:0] D4   = 44'h444_0000_0004;
  localparam logic [W-1:0] DABC = 44'hABC_DEF0_1234;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_start;
  logic          init_busy;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_din;
  logic [W-1:0]  ram_dout = '0;
  logic [1:0]    dbg_state;
  logic [W-1:0]  mem [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  openhw_ram1p_req_ctrl_if #(.DEPTH(DEPTH), .WIDTH(W)) bus_if ();

  openhw_ram1p_req_ctrl #(
    .DEPTH(DEPTH), .WIDTH(W), .INIT_ON_RESET(1'b1), .INIT_VALUE('0)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .init_busy(init_busy),
    .bus(bus_if), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // read-first single-port RAM; dout holds while ce is low
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_dout <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] data);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = we;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = data;
  endtask

  task automatic idle_req();
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [W-1:0] data);
    drive_req(1'b1, addr, data);
    #1;
    chk("wr_ready", 64'(bus_if.req_ready), 64'd1);
    chk("wr_ram_we", 64'(ram_we), 64'd1);
    tick();
    idle_req();
  endtask

  task automatic do_read_expect(input logic [AW-1:0] addr, input logic [W-1:0] exp);
    bus_if.rsp_ready = 1'b1;
    drive_req(1'b0, addr, '0);
    #1;
    chk("rd_ready", 64'(bus_if.req_ready), 64'd1);
    chk("rd_ram_ce", 64'(ram_ce), 64'd1);
    chk("rd_ram_we", 64'(ram_we), 64'd0);
    chk("rd_ram_addr", 64'(ram_addr), 64'(addr));
    tick();
    idle_req();
    #1;
    chk("rd_lat1_valid", 64'(bus_if.rsp_valid), 64'd0);
    tick();
    chk("rd_lat2_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("rd_data", 64'(bus_if.rsp_rdata), 64'(exp));
    tick();
    chk("rd_after_pop", 64'(bus_if.rsp_valid), 64'd0);
  endtask

  task automatic run_init(input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 10) init_start = 1'b0;
      #1;
      chk("init_ce", 64'(ram_ce), 64'd1);
      chk("init_we", 64'(ram_we), 64'd1);
      chk("init_addr", 64'(ram_addr), 64'(i));
      chk("init_din", 64'(ram_din), 64'd0);
      chk("init_busy", 64'(init_busy), 64'd1);
      chk("init_req_ready", 64'(bus_if.req_ready), 64'd0);
      chk("init_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
      tick();
    end
  endtask

  task automatic check_ready_state();
    #1;
    chk("rdy_busy", 64'(init_busy), 64'd0);
    chk("rdy_state", 64'(dbg_state), 64'd1);
    chk("rdy_req_ready", 64'(bus_if.req_ready), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = W'({$urandom, $urandom_range(32'hFFFF_FFFF, 1)});
    reset            = 1'b1;
    init_start       = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b1;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    bus_if.rsp_ready = 1'b0;
    tick();
    tick();
    // reset cycle gating
    chk("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
    chk("rst_ram_ce", 64'(ram_ce), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    chk("rst_busy", 64'(init_busy), 64'd1);
    reset = 1'b0;
    idle_req();
    init_start = 1'b1;
    run_init(DEPTH);
    check_ready_state();

    do_read_expect(6'd17, '0);

    // read-after-write
    do_write(6'd5, DABC);
    do_read_expect(6'd5, DABC);

    // back-pressure: only three reads accepted
    do_write(6'd1, D1);
    do_write(6'd2, D2);
    do_write(6'd3, D3);
    do_write(6'd4, D4);
    bus_if.rsp_ready = 1'b0;
    drive_req(1'b0, 6'd1, '0); #1;
    chk("bp_acc1", 64'(bus_if.req_ready), 64'd1);
    tick();
    drive_req(1'b0, 6'd2, '0); #1;
    chk("bp_acc2", 64'(bus_if.req_ready), 64'd1);
    tick();
    drive_req(1'b0, 6'd3, '0); #1;
    chk("bp_acc3", 64'(bus_if.req_ready), 64'd1);
    chk("bp_head_early", 64'(bus_if.rsp_rdata), 64'(D1));
    tick();
    drive_req(1'b0, 6'd4, '0); #1;
    chk("bp_rej4", 64'(bus_if.req_ready), 64'd0);
    chk("bp_rej4_ce", 64'(ram_ce), 64'd0);
    chk("bp_hold1", 64'(bus_if.rsp_rdata), 64'(D1));
    tick();
    chk("bp_rej4b", 64'(bus_if.req_ready), 64'd0);
    chk("bp_hold2", 64'(bus_if.rsp_rdata), 64'(D1));
    tick();
    chk("bp_rej4c", 64'(bus_if.req_ready), 64'd0);
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("bp_d1", 64'(bus_if.rsp_rdata), 64'(D1));
    chk("bp_no_comb_ready", 64'(bus_if.req_ready), 64'd0);
    tick();
    chk("bp_d2", 64'(bus_if.rsp_rdata), 64'(D2));
    chk("bp_acc4", 64'(bus_if.req_ready), 64'd1);
    chk("bp_acc4_addr", 64'(ram_addr), 64'd4);
    tick();
    idle_req(); #1;
    chk("bp_d3", 64'(bus_if.rsp_rdata), 64'(D3));
    tick();
    chk("bp_d4_valid", 64'(bus_if.rsp_valid), 64'd1);
    chk("bp_d4", 64'(bus_if.rsp_rdata), 64'(D4));
    tick();
    chk("bp_empty", 64'(bus_if.rsp_valid), 64'd0);

    // streaming: 16 back-to-back reads
    for (int k = 0; k < 16; k++) do_write(AW'(20 + k), W'(44'h5000 + k));
    bus_if.rsp_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive_req(1'b0, AW'(20 + k), '0);
      else idle_req();
      #1;
      if (k < 16) chk("st_ready", 64'(bus_if.req_ready), 64'd1);
      if (k >= 2) begin
        chk("st_valid", 64'(bus_if.rsp_valid), 64'd1);
        chk("st_data", 64'(bus_if.rsp_rdata), 64'(44'h5000 + k - 2));
      end
      tick();
    end
    chk("st_done", 64'(bus_if.rsp_valid), 64'd0);

    // drain with two reads outstanding, then clear
    bus_if.rsp_ready = 1'b0;
    drive_req(1'b0, 6'd1, '0); #1;
    chk("dr_acc1", 64'(bus_if.req_ready), 64'd1);
    tick();
    drive_req(1'b0, 6'd2, '0);
    init_start = 1'b1; #1;
    chk("dr_acc2", 64'(bus_if.req_ready), 64'd1);
    tick();
    init_start = 1'b0;
    drive_req(1'b0, 6'd3, '0); #1;
    chk("dr_state", 64'(dbg_state), 64'd2);
    chk("dr_busy", 64'(init_busy), 64'd1);
    chk("dr_no_acc", 64'(bus_if.req_ready), 64'd0);
    chk("dr_no_ce", 64'(ram_ce), 64'd0);
    chk("dr_d1", 64'(bus_if.rsp_rdata), 64'(D1));
    tick();
    idle_req();
    chk("dr_wait_state", 64'(dbg_state), 64'd2);
    chk("dr_valid", 64'(bus_if.rsp_valid), 64'd1);
    bus_if.rsp_ready = 1'b1;
    tick();
    chk("dr_d2", 64'(bus_if.rsp_rdata), 64'(D2));
    chk("dr_d2_state", 64'(dbg_state), 64'd2);
    tick();
    chk("dr_empty", 64'(bus_if.rsp_valid), 64'd0);
    chk("dr_last_state", 64'(dbg_state), 64'd2);
    tick();
    run_init(DEPTH);
    check_ready_state();
    do_read_expect(6'd5, '0);

    // reset in the middle of a clear
    init_start = 1'b1;
    tick();
    init_start = 1'b0; #1;
    chk("ri_drain", 64'(dbg_state), 64'd2);
    tick();
    run_init(30);
    chk("ri_addr30", 64'(ram_addr), 64'd30);
    reset = 1'b1; #1;
    chk("ri_rst_ce", 64'(ram_ce), 64'd0);
    chk("ri_rst_we", 64'(ram_we), 64'd0);
    tick();
    reset = 1'b0;
    run_init(DEPTH);
    check_ready_state();

    // reset with two responses buffered
    do_write(6'd7, 44'h777);
    do_write(6'd8, 44'h888);
    bus_if.rsp_ready = 1'b0;
    drive_req(1'b0, 6'd7, '0); #1;
    chk("rb_acc7", 64'(bus_if.req_ready), 64'd1);
    tick();
    drive_req(1'b0, 6'd8, '0); #1;
    chk("rb_acc8", 64'(bus_if.req_ready), 64'd1);
    tick();
    idle_req(); #1;
    chk("rb_valid", 64'(bus_if.rsp_valid), 64'd1);
    tick();
    chk("rb_head", 64'(bus_if.rsp_rdata), 64'h777);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("rb_dropped", 64'(bus_if.rsp_valid), 64'd0);
    chk("rb_init", 64'(dbg_state), 64'd0);
    run_init(DEPTH);
    check_ready_state();
    chk("rb_still_empty", 64'(bus_if.rsp_valid), 64'd0);
    do_read_expect(6'd7, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
